// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard front end: conditions the raw lines, deframes 11-bit frames
// and turns make codes (with E0/F0 prefixes) into one-cycle calculator key strobes.
`timescale 1ns/1ps
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50Mhz,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SC_EXT = 8'hE0;
  localparam logic [7:0]  SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic             filt_q, filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [4:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             frame_err_q, frame_err_d;

  logic             fall_c;
  logic             data_c;
  logic [5:0]       map_c;

  // Scan code to key code; bit 5 flags a mapped key.
  function automatic logic [5:0] map_key(input logic ext, input logic [7:0] sc);
    map_key = '0;
    if (ext) begin
      case (sc)
        8'h4A:   map_key = {1'b1, 5'd13};
        8'h5A:   map_key = {1'b1, 5'd14};
        default: map_key = '0;
      endcase
    end else begin
      case (sc)
        8'h45, 8'h70: map_key = {1'b1, 5'd0};
        8'h16, 8'h69: map_key = {1'b1, 5'd1};
        8'h1E, 8'h72: map_key = {1'b1, 5'd2};
        8'h26, 8'h7A: map_key = {1'b1, 5'd3};
        8'h25, 8'h6B: map_key = {1'b1, 5'd4};
        8'h2E, 8'h73: map_key = {1'b1, 5'd5};
        8'h36, 8'h74: map_key = {1'b1, 5'd6};
        8'h3D, 8'h6C: map_key = {1'b1, 5'd7};
        8'h3E, 8'h75: map_key = {1'b1, 5'd8};
        8'h46, 8'h7D: map_key = {1'b1, 5'd9};
        8'h79:        map_key = {1'b1, 5'd10};
        8'h7B, 8'h4E: map_key = {1'b1, 5'd11};
        8'h7C:        map_key = {1'b1, 5'd12};
        8'h5A, 8'h55: map_key = {1'b1, 5'd14};
        8'h66:        map_key = {1'b1, 5'd15};
        8'h76:        map_key = {1'b1, 5'd16};
        default:      map_key = '0;
      endcase
    end
  endfunction

  // Synchronizers and the clock stability filter.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    filt_d     = filt_q;
    flt_cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
    end
  end

  assign fall_c = filt_q & ~filt_d;
  assign data_c = dat_sync_q[1];

  // Frame deserializer with inter-edge timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tmo_d       = tmo_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == ST_IDLE || fall_c) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_c && !data_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_c) begin
          shift_d   = {data_c, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_c) begin
          par_ok_d = data_c ^ (^shift_q);
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_c) begin
          if (data_c && par_ok_q) begin
            byte_d     = shift_q;
            byte_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !fall_c && tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // Prefix tracking and key output, one cycle behind the accepted byte.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    map_c       = map_key(ext_q, byte_q);
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q && map_c[5]) begin
          key_code_d  = map_c[4:0];
          key_valid_d = 1'b1;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Keyboard front end of the calculator. It oversamples the PS/2 clock and data lines in the 50 MHz domain and deframes 11-bit set-2 scan-code frames. It tracks make, break (F0) and extended (E0) prefixes, and emits one 5-bit calculator key code per key press as a single-cycle strobe. The output feeds the number-forming stage directly: `key_code` drives its `data` input and `key_valid` drives its `cifra_noua` input, with no edge detector in between.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical synchronized samples required before the filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, 50000: idle limit in clocks (1 ms at 50 MHz) between filtered falling edges inside a frame.
- `clk_50Mhz`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to the system clock.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to the system clock.
- `key_code`  out  5  decoded key, held until the next valid key.
- `key_valid`  out  1  one-cycle strobe; `key_code` is valid in the same cycle.
- `frame_err`  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Input conditioning:
  - Two-flop synchronizer on each line.
  - `ps2_clk` passes through a `FILTER_LEN` stability filter; the filtered level resets to 1.
  - A filtered 1→0 transition is a "fall". `ps2_data` is sampled (synchronized value) in the fall cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a fall with data 0 (start bit) → DATA, bit counter 0. A fall with data 1 is ignored.
  - DATA: 8 falls shift data in LSB first → PARITY.
  - PARITY: the sampled bit plus the 8 data bits must have odd parity. Record the result → STOP.
  - STOP: on the fall, the stop bit must be 1 and parity must be OK; the byte is then accepted. Otherwise pulse `frame_err`. Either way → IDLE.
- Timeout: in any non-IDLE state, `TIMEOUT_CYCLES` clocks without a fall → IDLE, pulse `frame_err`, clear both prefix flags.
- Any error also clears both prefix flags.
- Byte interpretation for accepted bytes:
  - E0 sets `ext`. F0 sets `brk`. Neither produces output.
  - Any other byte: if `brk`=1, no output. Otherwise look the byte up with the `ext` qualifier. Either way, clear `ext` and `brk`.
- Map, hex scan code → `key_code`:
  - Digits 0–9, main row / keypad: 45/70→0, 16/69→1, 1E/72→2, 26/7A→3, 25/6B→4, 2E/73→5, 36/74→6, 3D/6C→7, 3E/75→8, 46/7D→9.
  - Operators: keypad 79 (+) → 10; 7B or 4E (−) → 11; keypad 7C (*) → 12; E0 4A (/) → 13.
  - 5A or E0 5A (Enter), or 55 (=) → 14.
  - 66 (Backspace) → 15.
  - 76 (Esc, clear) → 16.
- Unmapped codes, and E0 combined with any code other than 4A/5A, produce no output and no error.
- Typematic repeats (repeated makes without a break) each produce a `key_valid`.

## Timing
- Reset values: `key_code`=0, `key_valid`=0, `frame_err`=0. FSM=IDLE, flags cleared, filter output=1, filter counter=0, timeout counter=0.
- Reset asserted mid-frame aborts the frame; no strobe is emitted.
- Input latency: a raw `ps2_clk` edge reaches the filtered level after 2 + `FILTER_LEN` clocks.
- Output latency: `key_valid` and the new `key_code` are registered, asserting exactly 2 clocks after the stop-bit fall cycle. Cycle +1 latches the byte; cycle +2 drives the output.
- `frame_err` asserts 1 clock after the offending fall, or 1 clock after the timeout count reaches `TIMEOUT_CYCLES`.
- Strobes are exactly 1 cycle wide. They are never both high in the same cycle.
- Timeout counter: clears on every fall and in IDLE, and saturates at `TIMEOUT_CYCLES`.
- Minimum PS/2 bit period is 60 µs, much longer than any internal latency, so back-to-back frames need no buffering.

## Test plan
- Make code 3D, clean frame, 50 µs half-period → `key_valid` one cycle, `key_code`=7, exactly 2 clocks after the stop fall; `frame_err` stays 0.
- Sequence 3D, F0, 3D → exactly one `key_valid` (7). Then 79 → `key_valid`, `key_code`=10.
- Sequence E0, 4A → `key_code`=13. Then plain 4A (unmapped) → no strobe. Then E0, 5A → 14.
- Byte 16 sent with even parity → `frame_err` one cycle, no `key_valid`. Next clean frame 16 → `key_code`=1.
- Start bit plus 5 data bits, then silence → `frame_err` pulses `TIMEOUT_CYCLES` (+1) clocks after the last fall. Next full frame 45 → `key_code`=0.
- 100 ns low glitch on `ps2_clk` in IDLE → no state change. Reset pulse mid-frame → all outputs 0, FSM IDLE, next frame 66 → `key_code`=15.
